instr_fetch: RTL and testbench

//  Instruction-fetch stage of the LEGv8 core; sits directly upstream of the control unit.

---
 rtl/legv8_pkg.sv | 22 ++
 rtl/instr_fetch_pc_next.sv | 26 ++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: shared constants and types for the LEGv8 fetch path.
//   DEF_ADDR_W / DEF_INSTR_W : default address and instruction widths
//   OPCODE_W, OPC_HI, OPC_LO : opcode field [31:21] handed to the control unit
//   PC_INCR                  : sequential PC step (one 32-bit word)
//   fetch_state_e            : fetch FSM states
package legv8_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;
  localparam int OPCODE_W    = 11;
  localparam int OPC_HI      = 31;
  localparam int OPC_LO      = 21;
  localparam int PC_INCR     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// pc_next: combinational next-PC select for the fetch stage.
//   pc_i        : address of the instruction being accepted
//   br_offset_i : sign-extended word offset from the SEU
//   pc_src_i    : 1 = branch target, 0 = sequential
//   next_pc_o   : selected next PC, modulo 2^ADDR_W
module pc_next
  import legv8_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic              pc_src_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] seq_target;

  // The shift drops the top two offset bits and keeps the target word-aligned;
  // both sums wrap silently at 2^ADDR_W.
  assign br_target  = pc_i + (br_offset_i << 2);
  assign seq_target = pc_i + ADDR_W'(PC_INCR);
  assign next_pc_o  = pc_src_i ? br_target : seq_target;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: LEGv8 instruction-fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack memory port and
// presents it (plus opcode field [31:21]) to decode through valid/ready.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   imem_req/imem_addr            : fetch request, held (address stable) until ack
//   imem_ack/imem_rdata           : memory response, captured only in FETCH/WAIT
//   instr_valid/instr_ready       : decode handshake
//   instr, opcode, pc             : current instruction, its opcode field, its address
//   pc_src, br_offset             : next-PC select, sampled only on accept
//   fetch_cnt, stall_cnt          : perf counters, present only with IFETCH_PERF_EN
// Build option: define IFETCH_PERF_EN to add the accepted-instruction and
// WAIT-cycle counters.
module instr_fetch
  import legv8_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         stall_cnt,
`endif
  input  logic                pc_src,
  input  logic [ADDR_W-1:0]   br_offset
);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [INSTR_W-1:0]  instr_q;
  logic                accept;

  assign accept = (state_q == VALID) && instr_ready;

  pc_next #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .pc_i       (pc_q),
    .br_offset_i(br_offset),
    .pc_src_i   (pc_src),
    .next_pc_o  (pc_d)
  );

  // Fetch FSM; PC only moves on accept, so imem_addr is stable across WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH, WAIT: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= VALID;
          end else begin
            state_q <= WAIT;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc_q    <= pc_d;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset drops the request at once.
  assign imem_req    = (state_q == FETCH) || (state_q == WAIT);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign opcode      = instr_q[OPC_HI:OPC_LO];
  assign pc          = pc_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept)           fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == WAIT)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
// A behavioural memory (word = hash of address) answers requests with chosen or
// random delays; an address-level PC model predicts every fetch address.
module tb_instr_fetch;

  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic               clk;
  logic               rst;
  logic               imem_req;
  logic [63:0]        imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic [10:0]        opcode;
  logic [63:0]        pc;
  logic               pc_src;
  logic [63:0]        br_offset;
`ifdef IFETCH_PERF_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        stall_cnt;
`endif

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [63:0] exp_pc;
  int unsigned exp_fetch;
  int unsigned exp_stall;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .opcode     (opcode),
    .pc         (pc),
`ifdef IFETCH_PERF_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .pc_src     (pc_src),
    .br_offset  (br_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'hA5C3_1E77 ^ a[63:32];
  endfunction

  // One instruction: wait for request, stall `delay` cycles, ack, hold VALID
  // for `hold` cycles with ready low, then accept with the given branch choice.
  task automatic fetch_one(input int delay, input int hold, input bit src,
                           input logic [63:0] off, input bit chk_gap);
    int n;
    logic [31:0] w;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || (chk_gap && n != 0))
      $display("FAIL fetch_addr: req=%b addr=%h gap=%0d, want req=1 addr=%h gap=0",
               imem_req, imem_addr, n, exp_pc);
    else passed++;
    w = mem_word(exp_pc);
    for (int k = 0; k < delay; k++) begin
      imem_ack  = 1'b0;
      pc_src    = 1'b1;
      br_offset = {32'd0, $urandom};
      @(negedge clk);
      exp_stall++;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0)
        $display("FAIL wait_hold: req=%b addr=%h valid=%b, want 1 %h 0",
                 imem_req, imem_addr, instr_valid, exp_pc);
      else passed++;
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w ||
        opcode !== w[31:21] || pc !== exp_pc)
      $display("FAIL capture: valid=%b req=%b instr=%h op=%h pc=%h, want 1 0 %h %h %h",
               instr_valid, imem_req, instr, opcode, pc, w, w[31:21], exp_pc);
    else passed++;
    for (int k = 0; k < hold; k++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = ~w;
      pc_src      = 1'($urandom);
      br_offset   = {32'd0, $urandom};
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w ||
          opcode !== w[31:21] || pc !== exp_pc)
        $display("FAIL backpressure: valid=%b req=%b instr=%h pc=%h, want 1 0 %h %h",
                 instr_valid, imem_req, instr, pc, w, exp_pc);
      else passed++;
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    pc_src      = src;
    br_offset   = off;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    br_offset   = '0;
    exp_pc      = src ? exp_pc + off * 64'd4 : exp_pc + 64'd4;
    exp_fetch++;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pc_src = 1'b0; br_offset = '0;
    exp_pc = RESET_PC; exp_fetch = 0; exp_stall = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== RESET_PC || instr !== 32'd0)
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h, want 0 0 %h 0",
               imem_req, instr_valid, pc, instr, RESET_PC);
    else passed++;
  endtask

  task automatic test_sequential();
    fetch_one(0, 0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wait_states();
    fetch_one(3, 0, 1'b0, '0, 1'b1);               // pc 0x10 -> 0x14
    fetch_one(1, 0, 1'b1, 64'd3, 1'b1);            // 0x14 -> 0x20
  endtask

  task automatic test_branch();
    fetch_one(0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1); // 0x20 -> 0x18
    fetch_one(0, 0, 1'b0, '0, 1'b1);                       // 0x18 -> 0x1C
    fetch_one(0, 0, 1'b1, 64'd1, 1'b1);                    // 0x1C -> 0x20
    fetch_one(0, 0, 1'b0, '0, 1'b1);                       // 0x20 -> 0x24
  endtask

  task automatic test_backpressure();
    fetch_one(0, 5, 1'b0, '0, 1'b1);               // 0x24 -> 0x28
    fetch_one(0, 0, 1'b1, 64'd6, 1'b1);            // 0x28 -> 0x40
  endtask

  task automatic test_reset_mid_fetch();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h40)
      $display("FAIL pre_reset_addr: req=%b addr=%h, want 1 40", imem_req, imem_addr);
    else passed++;
    imem_ack = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC)
      $display("FAIL async_reset: req=%b valid=%b addr=%h, want 0 0 %h",
               imem_req, instr_valid, imem_addr, RESET_PC);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    exp_pc = RESET_PC; exp_fetch = 0; exp_stall = 0;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 32'd0)
      $display("FAIL restart: req=%b addr=%h valid=%b instr=%h, want 1 %h 0 0",
               imem_req, imem_addr, instr_valid, instr, RESET_PC);
    else passed++;
  endtask

  task automatic check_perf();
`ifdef IFETCH_PERF_EN
    checks++;
    if (fetch_cnt !== 32'(exp_fetch) || stall_cnt !== 32'(exp_stall))
      $display("FAIL perf_cnt: fetch=%0d stall=%0d, want %0d %0d",
               fetch_cnt, stall_cnt, exp_fetch, exp_stall);
    else passed++;
`endif
  endtask

  task automatic test_wrap();
    fetch_one(2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); // 0 -> 2^64-4
    fetch_one(0, 0, 1'b0, '0, 1'b1);                       // 2^64-4 -> 0
    fetch_one(0, 0, 1'b0, '0, 1'b1);
    check_perf();
  endtask

  task automatic test_random();
    int r;
    logic signed [63:0] so;
    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 16)) - 8;
      so = r;
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), so, 1'b1);
    end
    check_perf();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_backpressure();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
